demux2_8bit_buf: RTL and testbench

//  - Buffered 1-to-2 stream demultiplexer: the distribution counterpart of the 2:1 byte mux.
//  - Accepts one WIDTH-bit beat per cycle on a valid/ready input.
//  - Routes each beat to output 0 or 1, by explicit select or by round-robin.
//  - Each output has its own small FIFO, so a stalled consumer blocks only beats routed to it.

---
 rtl/demux2_8bit_buf_pkg.sv | 8 +
 rtl/demux2_8bit_buf_if.sv | 29 ++
 rtl/demux2_8bit_buf_fifo.sv | 48 ++++
 rtl/demux2_8bit_buf.sv | 51 +++++
 tb/tb_demux2_8bit_buf.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/demux2_8bit_buf_pkg.sv
// demux2_8bit_buf_pkg: shared selector/output encodings and default sizes for the buffered demux
package demux2_8bit_buf_pkg;
  localparam int DMX_WIDTH = 8;
  localparam int DMX_DEPTH = 2;
  localparam int DMX_AW = $clog2(DMX_DEPTH);
  typedef enum logic {SEL_EXPLICIT = 1'b0, SEL_RR = 1'b1} sel_mode_e;
  typedef enum logic {OUT0 = 1'b0, OUT1 = 1'b1} out_e;
endpackage

// File: rtl/demux2_8bit_buf_if.sv
// demux2_8bit_buf_if: input stream, select controls, both output streams and occupancy counts
interface demux2_8bit_buf_if
  import demux2_8bit_buf_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int AW = DMX_AW
);
  logic [WIDTH-1:0] d;
  logic d_valid;
  logic d_ready;
  logic s;
  logic mode;
  logic [WIDTH-1:0] y0;
  logic y0_valid;
  logic y0_ready;
  logic [WIDTH-1:0] y1;
  logic y1_valid;
  logic y1_ready;
  logic [AW:0] cnt0;
  logic [AW:0] cnt1;
  modport master (
    output d, d_valid, s, mode, y0_ready, y1_ready,
    input d_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
  );
  modport slave (
    input d, d_valid, s, mode, y0_ready, y1_ready,
    output d_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux2_8bit_buf_fifo.sv
// sync_fifo_8bit: single-clock FIFO; head is presented combinationally and reads as 0 while empty
module sync_fifo_8bit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push, pop;
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    empty = count_q == '0;
    push = wr_en & ~full;
    pop = rd_en & ~empty;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = (push & ~pop) ? count_q + (AW+1)'(1) :
              (pop & ~push) ? count_q - (AW+1)'(1) : count_q;
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/demux2_8bit_buf.sv
// demux2_8bit_buf: 1-to-2 stream demux with explicit or round-robin routing into per-output FIFOs
module demux2_8bit_buf
  import demux2_8bit_buf_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int DEPTH = DMX_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  demux2_8bit_buf_if.slave bus
);
  logic rr_q, rr_d;
  out_e tgt;
  logic d_ready, acc, wr0, wr1, rd0, rd1, v0, v1;
  logic full0, full1, empty0, empty1;
  logic [WIDTH-1:0] q0, q1;
  logic [AW:0] c0, c1;
  // readiness looks only at the target FIFO's registered fullness, never at d_valid or a same-cycle pop
  always_comb begin
    tgt = (bus.mode == SEL_RR) ? out_e'(rr_q) : out_e'(bus.s);
    d_ready = ~reset & ~((tgt == OUT1) ? full1 : full0);
    acc = bus.d_valid & d_ready;
    wr0 = acc & (tgt == OUT0);
    wr1 = acc & (tgt == OUT1);
    rr_d = (acc & (bus.mode == SEL_RR)) ? ~rr_q : rr_q;
    v0 = ~reset & ~empty0;
    v1 = ~reset & ~empty1;
    rd0 = v0 & bus.y0_ready;
    rd1 = v1 & bus.y1_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else rr_q <= rr_d;
  end
  sync_fifo_8bit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) fifo0 (
    .clk(clk), .reset(reset), .wr_en(wr0), .wr_data(bus.d), .rd_en(rd0),
    .rd_data(q0), .full(full0), .empty(empty0), .count(c0)
  );
  sync_fifo_8bit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) fifo1 (
    .clk(clk), .reset(reset), .wr_en(wr1), .wr_data(bus.d), .rd_en(rd1),
    .rd_data(q1), .full(full1), .empty(empty1), .count(c1)
  );
  assign bus.d_ready = d_ready;
  assign bus.y0_valid = v0;
  assign bus.y1_valid = v1;
  assign bus.y0 = reset ? '0 : q0;
  assign bus.y1 = reset ? '0 : q1;
  assign bus.cnt0 = reset ? '0 : c0;
  assign bus.cnt1 = reset ? '0 : c1;
endmodule

// File: tb/tb_demux2_8bit_buf.sv
// tb_demux2_8bit_buf: directed scenarios with hand-computed expectations for the buffered demux
module tb_demux2_8bit_buf;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  demux2_8bit_buf_if bus ();
  demux2_8bit_buf dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.d = 8'h55; bus.d_valid = 1'b1; bus.s = 1'b0; bus.mode = 1'b0;
    bus.y0_ready = 1'b0; bus.y1_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got=%0b exp=0", bus.d_ready); end
    checks++; if (bus.y0_valid !== 1'b0) begin errors++; $display("FAIL rst_y0_valid got=%0b exp=0", bus.y0_valid); end
    checks++; if (bus.y1_valid !== 1'b0) begin errors++; $display("FAIL rst_y1_valid got=%0b exp=0", bus.y1_valid); end
    checks++; if (bus.cnt0 !== 2'd0) begin errors++; $display("FAIL rst_cnt0 got=%0d exp=0", bus.cnt0); end
    checks++; if (bus.cnt1 !== 2'd0) begin errors++; $display("FAIL rst_cnt1 got=%0d exp=0", bus.cnt1); end
    checks++; if (bus.y0 !== 8'h00) begin errors++; $display("FAIL rst_y0 got=%h exp=00", bus.y0); end
    reset = 1'b0;
    bus.d_valid = 1'b0;
    tick();
    #1;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL rst_release_d_ready got=%0b exp=1", bus.d_ready); end
    checks++; if (bus.y0_valid !== 1'b0) begin errors++; $display("FAIL rst_release_y0_valid got=%0b exp=0", bus.y0_valid); end
  endtask

  task automatic test_explicit();
    bus.mode = 1'b0; bus.y0_ready = 1'b1; bus.y1_ready = 1'b1;
    bus.d = 8'h11; bus.s = 1'b0; bus.d_valid = 1'b1;
    #1;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL expl_ready got=%0b exp=1", bus.d_ready); end
    tick();
    bus.d = 8'h22; bus.s = 1'b1;
    #1;
    checks++; if (bus.y0_valid !== 1'b1 || bus.y0 !== 8'h11) begin errors++; $display("FAIL expl_y0_first got=%0b/%h exp=1/11", bus.y0_valid, bus.y0); end
    checks++; if (bus.y1_valid !== 1'b0) begin errors++; $display("FAIL expl_y1_idle got=%0b exp=0", bus.y1_valid); end
    tick();
    bus.d = 8'h33; bus.s = 1'b0;
    #1;
    checks++; if (bus.y1_valid !== 1'b1 || bus.y1 !== 8'h22) begin errors++; $display("FAIL expl_y1 got=%0b/%h exp=1/22", bus.y1_valid, bus.y1); end
    checks++; if (bus.y0_valid !== 1'b0) begin errors++; $display("FAIL expl_y0_drained got=%0b exp=0", bus.y0_valid); end
    tick();
    bus.d_valid = 1'b0; bus.s = 1'bx; bus.d = 8'hxx;
    #1;
    checks++; if (bus.y0_valid !== 1'b1 || bus.y0 !== 8'h33) begin errors++; $display("FAIL expl_y0_second got=%0b/%h exp=1/33", bus.y0_valid, bus.y0); end
    checks++; if (bus.y1_valid !== 1'b0) begin errors++; $display("FAIL expl_y1_drained got=%0b exp=0", bus.y1_valid); end
    tick();
    #1;
    checks++; if (bus.y0_valid !== 1'b0 || bus.cnt0 !== 2'd0) begin errors++; $display("FAIL expl_empty got=%0b/%0d exp=0/0", bus.y0_valid, bus.cnt0); end
    tick();
    #1;
    checks++; if (bus.cnt0 !== 2'd0 || bus.y0 !== 8'h00) begin errors++; $display("FAIL empty_pop got=%0d/%h exp=0/00", bus.cnt0, bus.y0); end
  endtask

  task automatic test_backpressure();
    bus.mode = 1'b0; bus.y0_ready = 1'b0; bus.y1_ready = 1'b0;
    bus.s = 1'b0; bus.d_valid = 1'b1; bus.d = 8'hA0;
    tick();
    bus.d = 8'hA1;
    tick();
    bus.d = 8'hA2;
    #1;
    checks++; if (bus.cnt0 !== 2'd2) begin errors++; $display("FAIL bp_cnt0 got=%0d exp=2", bus.cnt0); end
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_s0 got=%0b exp=0", bus.d_ready); end
    bus.s = 1'b1; bus.d = 8'hB0;
    #1;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_s1 got=%0b exp=1", bus.d_ready); end
    tick();
    bus.d_valid = 1'b0;
    #1;
    checks++; if (bus.y1_valid !== 1'b1 || bus.y1 !== 8'hB0) begin errors++; $display("FAIL bp_y1 got=%0b/%h exp=1/b0", bus.y1_valid, bus.y1); end
    checks++; if (bus.cnt0 !== 2'd2 || bus.y0 !== 8'hA0) begin errors++; $display("FAIL bp_fifo0_hold got=%0d/%h exp=2/a0", bus.cnt0, bus.y0); end
  endtask

  task automatic test_full_pop();
    bus.y1_ready = 1'b1;
    bus.y0_ready = 1'b1; bus.d_valid = 1'b1; bus.s = 1'b0; bus.mode = 1'b0; bus.d = 8'hC0;
    #1;
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL fp_ready_full got=%0b exp=0", bus.d_ready); end
    tick();
    bus.y0_ready = 1'b0;
    #1;
    checks++; if (bus.cnt0 !== 2'd1 || bus.y0 !== 8'hA1) begin errors++; $display("FAIL fp_after_pop got=%0d/%h exp=1/a1", bus.cnt0, bus.y0); end
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL fp_ready_freed got=%0b exp=1", bus.d_ready); end
    tick();
    bus.d_valid = 1'b0;
    #1;
    checks++; if (bus.cnt0 !== 2'd2 || bus.y0 !== 8'hA1) begin errors++; $display("FAIL fp_refill got=%0d/%h exp=2/a1", bus.cnt0, bus.y0); end
    checks++; if (bus.y1_valid !== 1'b0) begin errors++; $display("FAIL fp_y1_drained got=%0b exp=0", bus.y1_valid); end
    bus.y0_ready = 1'b1;
    tick();
    #1;
    checks++; if (bus.y0 !== 8'hC0 || bus.cnt0 !== 2'd1) begin errors++; $display("FAIL fp_order got=%h/%0d exp=c0/1", bus.y0, bus.cnt0); end
    tick();
    #1;
    checks++; if (bus.y0_valid !== 1'b0) begin errors++; $display("FAIL fp_drained got=%0b exp=0", bus.y0_valid); end
  endtask

  task automatic test_round_robin();
    bus.y0_ready = 1'b0; bus.y1_ready = 1'b0;
    bus.mode = 1'b0; bus.s = 1'b1; bus.d = 8'hEE; bus.d_valid = 1'b1;
    tick();
    bus.mode = 1'b1; bus.s = 1'b1; bus.d = 8'h01;
    tick();
    bus.s = 1'b0; bus.d = 8'h02;
    tick();
    bus.d = 8'h03;
    tick();
    bus.d = 8'h04;
    #1;
    checks++; if (bus.cnt0 !== 2'd2 || bus.cnt1 !== 2'd2) begin errors++; $display("FAIL rr_counts got=%0d/%0d exp=2/2", bus.cnt0, bus.cnt1); end
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL rr_stall got=%0b exp=0", bus.d_ready); end
    tick();
    bus.y1_ready = 1'b1;
    #1;
    checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL rr_stall_hold got=%0b exp=0", bus.d_ready); end
    tick();
    bus.y1_ready = 1'b0;
    #1;
    checks++; if (bus.d_ready !== 1'b1 || bus.y1 !== 8'h02) begin errors++; $display("FAIL rr_unstall got=%0b/%h exp=1/02", bus.d_ready, bus.y1); end
    tick();
    bus.d_valid = 1'b0; bus.mode = 1'bx;
    #1;
    checks++; if (bus.cnt1 !== 2'd2 || bus.cnt0 !== 2'd2) begin errors++; $display("FAIL rr_04_to_y1 got=%0d/%0d exp=2/2", bus.cnt0, bus.cnt1); end
    bus.y0_ready = 1'b1; bus.y1_ready = 1'b1;
    #1;
    checks++; if (bus.y0 !== 8'h01 || bus.y1 !== 8'h02) begin errors++; $display("FAIL rr_head got=%h/%h exp=01/02", bus.y0, bus.y1); end
    tick();
    #1;
    checks++; if (bus.y0 !== 8'h03 || bus.y1 !== 8'h04) begin errors++; $display("FAIL rr_tail got=%h/%h exp=03/04", bus.y0, bus.y1); end
    tick();
    #1;
    checks++; if (bus.y0_valid !== 1'b0 || bus.y1_valid !== 1'b0) begin errors++; $display("FAIL rr_drained got=%0b/%0b exp=0/0", bus.y0_valid, bus.y1_valid); end
  endtask

  task automatic test_reset_mid();
    bus.y0_ready = 1'b0; bus.y1_ready = 1'b0;
    bus.mode = 1'b1; bus.d = 8'h61; bus.d_valid = 1'b1;
    tick();
    bus.mode = 1'b0; bus.s = 1'b0; bus.d = 8'h62;
    tick();
    bus.s = 1'b1; bus.d = 8'h63;
    tick();
    bus.d_valid = 1'b0;
    #1;
    checks++; if (bus.cnt0 !== 2'd2 || bus.cnt1 !== 2'd1) begin errors++; $display("FAIL mid_pre got=%0d/%0d exp=2/1", bus.cnt0, bus.cnt1); end
    reset = 1'b1;
    #1;
    checks++; if (bus.y0_valid !== 1'b0 || bus.d_ready !== 1'b0) begin errors++; $display("FAIL mid_in_reset got=%0b/%0b exp=0/0", bus.y0_valid, bus.d_ready); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.cnt0 !== 2'd0 || bus.cnt1 !== 2'd0) begin errors++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", bus.cnt0, bus.cnt1); end
    checks++; if (bus.y0_valid !== 1'b0 || bus.y1_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0b/%0b exp=0/0", bus.y0_valid, bus.y1_valid); end
    bus.mode = 1'b1; bus.s = 1'b1; bus.d = 8'h70; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    #1;
    checks++; if (bus.y0_valid !== 1'b1 || bus.y0 !== 8'h70) begin errors++; $display("FAIL mid_rr_restart got=%0b/%h exp=1/70", bus.y0_valid, bus.y0); end
    checks++; if (bus.y1_valid !== 1'b0) begin errors++; $display("FAIL mid_rr_y1 got=%0b exp=0", bus.y1_valid); end
  endtask

  initial begin
    test_reset();
    test_explicit();
    test_backpressure();
    test_full_pop();
    test_round_robin();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
